// File: rtl/tx_pkg.sv
// Shared definitions for the transmitter sample pacer: control-word field
// positions and the pacer state encoding.
package tx_pkg;

    // Bit positions inside the 32-bit control word.
    localparam int CTL_ENABLE       = 0;
    localparam int CTL_FLUSH        = 1;
    localparam int CTL_CLR_UNDERRUN = 2;

    // Pacer operating states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIMING = 2'd1,
        ST_RUNNING = 2'd2
    } tx_pacer_state_t;

endpackage

// File: rtl/tx_sample_fifo.sv
// Synchronous FIFO holding pending AM sample words. Flush empties it and
// overrides any push or pop issued in the same cycle. Level, full and empty
// are registered so downstream handshakes see a clean state.
module tx_sample_fifo #(
    parameter int FIFO_LOG2 = 4,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic [FIFO_LOG2:0]   level_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2-1:0] PTR_ZERO  = {FIFO_LOG2{1'b0}};
    localparam logic [FIFO_LOG2-1:0] PTR_ONE   = {{(FIFO_LOG2-1){1'b0}}, 1'b1};
    localparam logic [FIFO_LOG2:0]   LVL_ZERO  = {(FIFO_LOG2+1){1'b0}};
    localparam logic [FIFO_LOG2:0]   LVL_ONE   = {{FIFO_LOG2{1'b0}}, 1'b1};
    localparam logic [FIFO_LOG2:0]   LVL_FULL  = {1'b1, {FIFO_LOG2{1'b0}}};

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   level_q, level_d;
    logic                 full_q;
    logic                 empty_q;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    assign push_ok_s = push_i & ~full_q & ~flush_i;
    assign pop_ok_s  = pop_i & ~empty_q & ~flush_i;

    // Pointer and occupancy bookkeeping; flush resets everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            level_d  = LVL_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            level_q  <= LVL_ZERO;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LVL_FULL);
            empty_q  <= (level_d == LVL_ZERO);
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/tx_sample_pacer.sv
// Releases buffered AM samples at a fixed sample rate, aligns frequency
// updates to sample ticks and drives the registered amplitude, frequency and
// enable seen by the RF synthesis datapath. Underruns are flagged sticky.
module tx_sample_pacer
    import tx_pkg::*;
#(
    parameter int SAMPLE_DIV = 2500,
    parameter int FIFO_LOG2  = 4,
    parameter int AM_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          input_am,
    input  logic                 input_am_stb,
    output logic                 input_am_ack,
    input  logic [31:0]          input_freq,
    input  logic                 input_freq_stb,
    output logic                 input_freq_ack,
    input  logic [31:0]          input_ctl,
    input  logic                 input_ctl_stb,
    output logic                 input_ctl_ack,
    output logic [31:0]          frequency,
    output logic [AM_WIDTH-1:0]  amplitude,
    output logic                 tx_enable,
    output logic                 sample_strobe,
    output logic                 underrun,
    output logic [FIFO_LOG2:0]   fifo_level
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(SAMPLE_DIV - 1);
    // Half-full threshold that ends priming.
    localparam logic [FIFO_LOG2:0]  PRIME_LEVEL = {2'b01, {(FIFO_LOG2-1){1'b0}}};
    localparam logic [AM_WIDTH-1:0] AMP_ZERO    = {AM_WIDTH{1'b0}};

    tx_pacer_state_t     state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         frequency_q, frequency_d;
    logic [31:0]         pend_word_q, pend_word_d;
    logic                pend_q, pend_d;
    logic [AM_WIDTH-1:0] amplitude_q, amplitude_d;
    logic                tx_enable_q;
    logic                strobe_q;
    logic                underrun_q, underrun_d;
    logic                freq_ack_q;
    logic                ctl_ack_q;
    logic                am_rdy_q;

    logic                am_fire_s;
    logic                freq_fire_s;
    logic                ctl_fire_s;
    logic                ctl_flush_s;
    logic                ctl_clr_s;
    logic                tick_s;
    logic                pop_s;
    logic [31:0]         fifo_rdata_s;
    logic [FIFO_LOG2:0]  fifo_level_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                unused_bits_s;

    // AM ack is withheld until the first edge after reset and while full.
    assign input_am_ack = am_rdy_q & ~fifo_full_s;

    assign am_fire_s   = input_am_stb & input_am_ack;
    assign freq_fire_s = input_freq_stb & freq_ack_q;
    assign ctl_fire_s  = input_ctl_stb & ctl_ack_q;
    assign ctl_flush_s = ctl_fire_s & input_ctl[CTL_FLUSH];
    assign ctl_clr_s   = ctl_fire_s & input_ctl[CTL_CLR_UNDERRUN];

    assign unused_bits_s = ^{input_ctl[31:3], fifo_rdata_s[31:AM_WIDTH]};

    tx_sample_fifo #(
        .FIFO_LOG2 (FIFO_LOG2),
        .WIDTH     (32)
    ) u_fifo (
        .clk     (clk),
        .rst_ni  (rst),
        .push_i  (am_fire_s),
        .wdata_i (input_am),
        .pop_i   (pop_s),
        .flush_i (ctl_flush_s),
        .rdata_o (fifo_rdata_s),
        .level_o (fifo_level_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next-state decode: a disable write wins from any state, flush drops
    // a running pacer back to priming.
    always_comb begin
        state_d = state_q;
        if (ctl_fire_s && !input_ctl[CTL_ENABLE]) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctl_fire_s) begin
                        state_d = ST_PRIMING;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRIMING: begin
                    if (!ctl_flush_s && (fifo_level_s >= PRIME_LEVEL)) begin
                        state_d = ST_RUNNING;
                    end else begin
                        state_d = ST_PRIMING;
                    end
                end
                ST_RUNNING: begin
                    if (ctl_flush_s) begin
                        state_d = ST_PRIMING;
                    end else begin
                        state_d = ST_RUNNING;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A tick only counts when the pacer also stays running through it.
    assign tick_s = (state_q == ST_RUNNING) && (cnt_q == CNT_LAST) &&
                    (state_d == ST_RUNNING);
    assign pop_s  = tick_s & ~fifo_empty_s;

    // Sample-rate divider: runs only while RUNNING, otherwise parked at 0.
    always_comb begin
        cnt_d = CNT_ZERO;
        if ((state_q == ST_RUNNING) && (state_d == ST_RUNNING)) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    // Amplitude and underrun updates; clear beats a coincident set.
    always_comb begin
        amplitude_d = amplitude_q;
        underrun_d  = underrun_q;
        if (state_d == ST_IDLE) begin
            amplitude_d = AMP_ZERO;
        end else if (pop_s) begin
            amplitude_d = fifo_rdata_s[AM_WIDTH-1:0];
        end else begin
            amplitude_d = amplitude_q;
        end
        if (ctl_clr_s) begin
            underrun_d = 1'b0;
        end else if (tick_s && fifo_empty_s) begin
            underrun_d = 1'b1;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Frequency path: while running, words wait in the pending register for
    // the next tick; otherwise they go straight to the output.
    always_comb begin
        frequency_d = frequency_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        if (state_q == ST_RUNNING) begin
            if (tick_s && pend_q) begin
                frequency_d = pend_word_q;
                pend_d      = 1'b0;
            end else begin
                frequency_d = frequency_q;
            end
            if (freq_fire_s) begin
                pend_d      = 1'b1;
                pend_word_d = input_freq;
            end else begin
                pend_word_d = pend_word_q;
            end
        end else begin
            if (pend_q) begin
                frequency_d = pend_word_q;
                pend_d      = 1'b0;
            end else if (freq_fire_s) begin
                frequency_d = input_freq;
            end else begin
                frequency_d = frequency_q;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            frequency_q <= 32'd0;
            pend_word_q <= 32'd0;
            pend_q      <= 1'b0;
            amplitude_q <= AMP_ZERO;
            tx_enable_q <= 1'b0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
            freq_ack_q  <= 1'b0;
            ctl_ack_q   <= 1'b0;
            am_rdy_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frequency_q <= frequency_d;
            pend_word_q <= pend_word_d;
            pend_q      <= pend_d;
            amplitude_q <= amplitude_d;
            tx_enable_q <= (state_d == ST_RUNNING);
            strobe_q    <= tick_s;
            underrun_q  <= underrun_d;
            freq_ack_q  <= ~pend_d;
            ctl_ack_q   <= 1'b1;
            am_rdy_q    <= 1'b1;
        end
    end

    assign input_freq_ack = freq_ack_q;
    assign input_ctl_ack  = ctl_ack_q;
    assign frequency      = frequency_q;
    assign amplitude      = amplitude_q;
    assign tx_enable      = tx_enable_q;
    assign sample_strobe  = strobe_q;
    assign underrun       = underrun_q;
    assign fifo_level     = fifo_level_s;

endmodule
